register_bank_param: RTL
========================

Name: register_bank_param

Overview:
- Parametrised successor of the 16-bit register bank in the datapath.
- Contains a configurable array of general registers, with two asynchronous read ports (A, B) and one write port (C).
- Also provides memory-mapped input registers with a synchroniser and change flags, memory-mapped output registers, and a W register loaded from memory.
- Adds a synchronous reset, an explicit write enable, read-only input slots and optional write-to-read bypass.

Parameters:
- WIDTH, 16, data width of every register and bus.
- ADDR_W, 6, width of A_CTRL/B_CTRL/C_CTRL.
- NUM_REGS, 35, number of addressable registers (0..NUM_REGS-1); must be <= 2**ADDR_W.
- NUM_IN, 2, number of input registers.
- IN_BASE, 28, address of input register 0; inputs occupy IN_BASE..IN_BASE+NUM_IN-1.
- NUM_OUT, 2, number of output registers.
- OUT_BASE, 30, address of output register 0; outputs occupy OUT_BASE..OUT_BASE+NUM_OUT-1.
- W_ADDR, 34, address of the W register.
- SYNC_STAGES, 2, flop stages on each input bus before its input register (>=1).
- BYPASS, 1, 1 = same-cycle write data forwarded to A/B reads; 0 = reads show stored value only.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- A_CTRL  in  ADDR_W  read address, port A.
- B_CTRL  in  ADDR_W  read address, port B.
- C_CTRL  in  ADDR_W  write address, port C.
- C_WE  in  1  write enable, port C.
- FROM_C  in  WIDTH  write data, port C.
- MR  in  1  load W register from TO_W.
- TO_W  in  WIDTH  memory read data for W.
- IN_BUS  in  NUM_IN*WIDTH  external inputs; input k is at bits [k*WIDTH +: WIDTH].
- CHG_CLR  in  NUM_IN  per-input pulse that clears the change flag.
- TO_A  out  WIDTH  read data, port A.
- TO_B  out  WIDTH  read data, port B.
- FROM_W  out  WIDTH  current W register.
- OUT_BUS  out  NUM_OUT*WIDTH  output registers; output k is at bits [k*WIDTH +: WIDTH].
- IN_CHG  out  NUM_IN  sticky change flags.

Behaviour:
- Clock and reset: single clock CLK. Reset RST is synchronous, active-high.
- Reset values: all registers, synchroniser flops and IN_CHG are 0. So FROM_W, OUT_BUS and IN_CHG are 0 the cycle after the reset edge. RST overrides C, MR and input capture in that cycle.
- Reads:
  - TO_A and TO_B are combinational from the address and stored state.
  - An address >= NUM_REGS reads 0.
  - A and B are fully independent; both may read the same address.
- Writes:
  - When C_WE=1 and C_CTRL < NUM_REGS, and C_CTRL is not an input address, the register at C_CTRL takes FROM_C at the edge.
  - A write to an input address is ignored.
  - A write to an out-of-range address is ignored, with no aliasing.
  - C_WE=0 means no write, whatever the value of C_CTRL.
- W register:
  - MR=1 loads TO_W into W_ADDR.
  - If MR=1 and a C write targets W_ADDR in the same cycle, MR wins.
  - W is readable through A/B like any other register.
  - FROM_W continuously drives the register at W_ADDR.
- Output registers: ordinary writable registers. OUT_BUS mirrors them, with 1-cycle latency from a C write.
- Input path:
  - Each input passes through a SYNC_STAGES flop chain, then is loaded into its input register every cycle.
  - Latency from an IN_BUS change to its A/B visibility is SYNC_STAGES+1 edges.
- Change flags:
  - IN_CHG[k] sets at the edge where the incoming synchronised value differs from the current input register value.
  - CHG_CLR[k] clears IN_CHG[k].
  - If set and clear occur in the same cycle, set wins.
- Bypass (BYPASS=1, RST=0):
  - If a read address equals an address being written this cycle (valid C write, or MR at W_ADDR), TO_A/TO_B return the incoming data, with MR data taking priority.
  - Input addresses are never bypassed.
  - With BYPASS=0, a read shows the old value until after the edge.
  - While RST=1 there is no bypass.
- Elaboration checks:
  - The input range, output range and W_ADDR must all lie below NUM_REGS.
  - The input range, output range and W_ADDR must not overlap one another.
  - Violating either check is a fatal error.

Test Plan:
- Reset: preload regs 0, 30, 34 with non-zero values; hold RST for 1 cycle with C_WE=1, MR=1 -> TO_A(0)=0, OUT_BUS=0, FROM_W=0, IN_CHG=0.
- Write/read: C_WE=1, C_CTRL=5, FROM_C=0xBEEF; A_CTRL=B_CTRL=5. With BYPASS=1 -> TO_A=TO_B=0xBEEF in the same cycle. With BYPASS=0 -> 0xBEEF only after the edge. C_WE=0, C_CTRL=5, FROM_C=0x1234 -> reg 5 stays 0xBEEF.
- Boundaries: write 0xAAAA to address 35 and to 63 -> no register changes, TO_A(35)=0. Write 0x5555 to 28 -> reg 28 keeps the synchronised IN value.
- W priority: MR=1, TO_W=0x00FF, and C write 0xFF00 to 34 in the same cycle -> FROM_W=0x00FF. Bypass read of 34 in that cycle -> 0x00FF.
- Input latency and flags: IN_BUS input 1 changes 0 -> 0x0042 -> TO_A(29)=0x0042 exactly 3 edges later (SYNC_STAGES=2), and IN_CHG[1]=1 on the same edge. Pulse CHG_CLR[1] with no change -> IN_CHG[1]=0. Assert CHG_CLR[1] on the edge of a new change -> IN_CHG[1] stays 1.
- Output mirror: write 0x1357 to 31 -> OUT_BUS[31:16]=0x1357 after 1 edge, OUT_BUS[15:0] unchanged. Re-elaborate with NUM_OUT=4, OUT_BASE=30 placed below NUM_REGS and W_ADDR moved outside 30..33 -> all 4 slots mirror their writes.

Source files
------------

// File: rtl/register_bank_if.sv
// register_bank_if: read/write/memory-mapped I/O signal bundle for register_bank_param
interface register_bank_if #(
  parameter int WIDTH = 16,
  parameter int ADDR_W = 6,
  parameter int NUM_IN = 2,
  parameter int NUM_OUT = 2
);
  logic [ADDR_W-1:0] A_CTRL, B_CTRL, C_CTRL;
  logic C_WE, MR;
  logic [WIDTH-1:0] FROM_C, TO_W, TO_A, TO_B, FROM_W;
  logic [NUM_IN*WIDTH-1:0] IN_BUS;
  logic [NUM_IN-1:0] CHG_CLR, IN_CHG;
  logic [NUM_OUT*WIDTH-1:0] OUT_BUS;
  modport master (
    output A_CTRL, B_CTRL, C_CTRL, C_WE, FROM_C, MR, TO_W, IN_BUS, CHG_CLR,
    input TO_A, TO_B, FROM_W, OUT_BUS, IN_CHG
  );
  modport slave (
    input A_CTRL, B_CTRL, C_CTRL, C_WE, FROM_C, MR, TO_W, IN_BUS, CHG_CLR,
    output TO_A, TO_B, FROM_W, OUT_BUS, IN_CHG
  );
endinterface

// File: rtl/register_bank_param.sv
// register_bank_param: general registers with A/B reads, C write, synchronised inputs, mirrored outputs and W register
module register_bank_param #(
  parameter int WIDTH = 16,
  parameter int ADDR_W = 6,
  parameter int NUM_REGS = 35,
  parameter int NUM_IN = 2,
  parameter int IN_BASE = 28,
  parameter int NUM_OUT = 2,
  parameter int OUT_BASE = 30,
  parameter int W_ADDR = 34,
  parameter int SYNC_STAGES = 2,
  parameter int BYPASS = 1
) (
  input logic CLK,
  input logic RST,
  register_bank_if.slave bus
);
  if (IN_BASE + NUM_IN > NUM_REGS || OUT_BASE + NUM_OUT > NUM_REGS || W_ADDR >= NUM_REGS ||
      NUM_REGS > 2**ADDR_W || SYNC_STAGES < 1) begin : g_range_err
    $fatal(1, "register_bank_param: mapped region lies outside the register range");
  end
  if ((IN_BASE < OUT_BASE + NUM_OUT && OUT_BASE < IN_BASE + NUM_IN) ||
      (W_ADDR >= IN_BASE && W_ADDR < IN_BASE + NUM_IN) ||
      (W_ADDR >= OUT_BASE && W_ADDR < OUT_BASE + NUM_OUT)) begin : g_overlap_err
    $fatal(1, "register_bank_param: input, output and W regions overlap");
  end
  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] nxt [NUM_REGS];
  logic [WIDTH-1:0] sync_q [NUM_IN][SYNC_STAGES];
  logic [NUM_IN-1:0] chg_set;
  logic wr_c;
  function automatic logic is_in(input logic [ADDR_W-1:0] a);
    return 32'(a) >= IN_BASE && 32'(a) < IN_BASE + NUM_IN;
  endfunction
  // Bypass mirrors the write priority: MR to W beats a C write to the same address.
  function automatic logic [WIDTH-1:0] rd(input logic [ADDR_W-1:0] a);
    logic byp;
    byp = BYPASS != 0 && !RST && !is_in(a);
    return 32'(a) >= NUM_REGS ? '0 :
           byp && bus.MR && 32'(a) == W_ADDR ? bus.TO_W :
           byp && wr_c && a == bus.C_CTRL ? bus.FROM_C : regs[a];
  endfunction
  assign wr_c = bus.C_WE && 32'(bus.C_CTRL) < NUM_REGS && !is_in(bus.C_CTRL);
  always_comb bus.TO_A = rd(bus.A_CTRL);
  always_comb bus.TO_B = rd(bus.B_CTRL);
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i >= IN_BASE && i < IN_BASE + NUM_IN) begin : g_in
      assign nxt[i] = sync_q[i-IN_BASE][SYNC_STAGES-1];
      assign chg_set[i-IN_BASE] = nxt[i] != regs[i];
    end else begin : g_rw
      assign nxt[i] = bus.MR && i == W_ADDR ? bus.TO_W :
                      wr_c && bus.C_CTRL == ADDR_W'(i) ? bus.FROM_C : regs[i];
    end
  end
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign bus.OUT_BUS[k*WIDTH +: WIDTH] = regs[OUT_BASE+k];
  end
  assign bus.FROM_W = regs[W_ADDR];
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST ? '0 : nxt[i];
    for (int k = 0; k < NUM_IN; k++) begin
      sync_q[k][0] <= RST ? '0 : bus.IN_BUS[k*WIDTH +: WIDTH];
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[k][s] <= RST ? '0 : sync_q[k][s-1];
    end
    bus.IN_CHG <= RST ? '0 : chg_set | (bus.IN_CHG & ~bus.CHG_CLR);
  end
endmodule
